// File: rtl/fetch_pc_pkg.sv
// Shared CPU constants for the fetch stage: fetch addresses, the legal
// instruction-memory window and the fetch FSM state encoding.
package fetch_pc_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;
    localparam logic [31:0] IM_LO_DEF    = 32'h0000_3000;
    localparam logic [31:0] IM_HI_DEF    = 32'h0000_6FFC;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HOLD      = 2'd1,
        ST_HOLD_PEND = 2'd2
    } fetch_state_e;

    // A fetch address is bad when it is not word aligned or lies outside [lo, hi].
    function automatic logic fetch_addr_err(input logic [31:0] addr,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
        return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
    endfunction

endpackage

// File: rtl/fetch_pc_if.sv
// Bundle between the fetch PC unit and the rest of the pipeline
// (hazard unit, decode redirect, exception unit, instruction memory).
interface fetch_pc_if;
    import fetch_pc_pkg::*;

    logic         Stall;
    logic         BrValid;
    logic [31:0]  BrTarget;
    logic         ExcValid;
    logic         EretValid;
    logic [31:0]  EPC;
    logic [31:0]  PC;
    logic [31:0]  PC4;
    logic         Fire;
    logic         AdEL;
    fetch_state_e State;

    modport master (
        output Stall, BrValid, BrTarget, ExcValid, EretValid, EPC,
        input  PC, PC4, Fire, AdEL, State
    );

    modport slave (
        input  Stall, BrValid, BrTarget, ExcValid, EretValid, EPC,
        output PC, PC4, Fire, AdEL, State
    );

endinterface

// File: rtl/fetch_pc.sv
// Fetch program counter: next-PC selection with exception/eret priority,
// stall hold and a one-deep pending redirect that survives stalls.
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_PC   = EXC_PC_DEF,
    parameter logic [31:0] IM_LO    = IM_LO_DEF,
    parameter logic [31:0] IM_HI    = IM_HI_DEF
) (
    input  logic       clk,
    input  logic       reset,
    fetch_pc_if.slave  fp
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  pend_tgt_q, pend_tgt_d;
    logic [31:0]  pc4_s;
    logic         adel_s;

    assign pc4_s  = pc_q + 32'd4;
    assign adel_s = fetch_addr_err(pc_q, IM_LO, IM_HI);

    assign fp.PC    = pc_q;
    assign fp.PC4   = pc4_s;
    assign fp.AdEL  = adel_s;
    assign fp.Fire  = !fp.Stall && !adel_s && !reset;
    assign fp.State = state_q;

    // Next-PC priority, pending-redirect bookkeeping and FSM next state.
    always_comb begin
        state_d      = ST_RUN;
        pc_d         = pc4_s;
        pend_valid_d = pend_valid_q;
        pend_tgt_d   = pend_tgt_q;

        if (fp.ExcValid) begin
            pc_d         = EXC_PC;
            pend_valid_d = 1'b0;
            pend_tgt_d   = 32'd0;
            state_d      = ST_RUN;
        end else if (fp.EretValid) begin
            pc_d         = fp.EPC;
            pend_valid_d = 1'b0;
            pend_tgt_d   = 32'd0;
            state_d      = ST_RUN;
        end else if (fp.Stall) begin
            pc_d = pc_q;
            if (fp.BrValid) begin
                // A newer redirect replaces whatever was already waiting.
                pend_valid_d = 1'b1;
                pend_tgt_d   = fp.BrTarget;
            end else begin
                pend_valid_d = pend_valid_q;
                pend_tgt_d   = pend_tgt_q;
            end
            case (state_q)
                ST_RUN:       state_d = fp.BrValid ? ST_HOLD_PEND : ST_HOLD;
                ST_HOLD:      state_d = fp.BrValid ? ST_HOLD_PEND : ST_HOLD;
                ST_HOLD_PEND: state_d = ST_HOLD_PEND;
                default:      state_d = ST_RUN;
            endcase
        end else begin
            // A live redirect outranks a pending one arriving on the same edge.
            if (fp.BrValid) begin
                pc_d = fp.BrTarget;
            end else if (pend_valid_q) begin
                pc_d = pend_tgt_q;
            end else begin
                pc_d = pc4_s;
            end
            pend_valid_d = 1'b0;
            pend_tgt_d   = 32'd0;
            state_d      = ST_RUN;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_tgt_q   <= pend_tgt_d;
        end
    end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, is the PC loaded on reset.
REQ-002 Parameter EXC_PC, default 32'h0000_4180, is the exception handler entry address.
REQ-003 Parameters IM_LO / IM_HI, defaults 32'h0000_3000 / 32'h0000_6FFC, bound the legal fetch range (inclusive).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 Stall  in  1  hazard unit: hold fetch this cycle.
REQ-007 BrValid  in  1  decode-stage redirect pulse (taken branch or jump), one cycle wide.
REQ-008 BrTarget  in  32  redirect address, already computed as offset + PC + 4.
REQ-009 ExcValid  in  1  exception redirect request.
REQ-010 EretValid  in  1  return-from-exception request.
REQ-011 EPC  in  32  eret return address.
REQ-012 PC  out  32  current fetch address, registered.
REQ-013 PC4  out  32  PC + 4, combinational from PC.
REQ-014 Fire  out  1  instruction fetched this cycle is valid for decode.
REQ-015 AdEL  out  1  PC misaligned (PC[1:0] != 0) or outside [IM_LO, IM_HI].

Function
REQ-016 Next-PC priority, highest first: ExcValid -> EXC_PC; EretValid -> EPC; Stall -> hold; pending or live redirect -> target; else PC + 4.
REQ-017 ExcValid and EretValid SHALL take effect on the next edge regardless of Stall and SHALL clear any pending redirect.
REQ-018 Redirect latency: BrValid in cycle n with Stall=0 -> PC = BrTarget in cycle n+1.
REQ-019 BrValid with Stall=1 SHALL capture BrTarget in a pending register; the PC holds.
REQ-020 Pending redirect SHALL be applied on the first edge with Stall=0, then cleared.
REQ-021 BrValid while a redirect is already pending: the newer target SHALL overwrite the pending one.
REQ-022 BrValid on the same edge a pending redirect would apply: the live BrTarget wins and pending clears.
REQ-023 States: RUN (sequential), HOLD (Stall=1, nothing pending), HOLD_PEND (Stall=1, redirect pending).
REQ-024 Transitions: RUN->HOLD on Stall without BrValid; RUN/HOLD->HOLD_PEND on Stall with BrValid; HOLD/HOLD_PEND->RUN when Stall=0; any state->RUN on ExcValid/EretValid.
REQ-025 PC + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); no carry out.
REQ-026 Fire = !Stall && !AdEL; Fire SHALL be 0 while reset is high.
REQ-027 AdEL is purely combinational from PC; it SHALL NOT alter next-PC selection (the exception unit responds via ExcValid).

Reset
REQ-028 On reset: PC = RESET_PC, state = RUN, pending valid = 0, pending target = 0.
REQ-029 Reset SHALL override Stall, BrValid, ExcValid and EretValid in the same cycle.
REQ-030 Reset asserted mid-HOLD_PEND SHALL discard the pending redirect.

Structure
REQ-031 RESET_PC, EXC_PC, IM_LO, IM_HI and the state encoding SHALL live in the shared CPU constants package.
REQ-032 No sub-module; incrementer, pending register and FSM are inline in fetch_pc.

Verification
REQ-033 Reset release, no stall, 3 cycles -> PC = 3000, 3004, 3008; Fire = 1; AdEL = 0.
REQ-034 PC = 3008, BrValid=1 with BrTarget=3100, Stall=0 -> next PC = 3100.
REQ-035 PC = 3010, Stall=1 for 3 cycles with BrValid pulse (BrTarget=3200) in the first of them -> PC holds 3010, state HOLD_PEND; first unstalled edge -> PC = 3200, then 3204.
REQ-036 Stall=1 with redirect pending, ExcValid=1 -> PC = 4180 next edge; pending cleared; later unstall -> 4184, not the stale target.
REQ-037 EretValid=1 with EPC=3FFC -> PC = 3FFC; then 4000; BrTarget=3002 -> AdEL=1, Fire=0; PC forced to FFFFFFFC -> next PC = 00000000.
REQ-038 Reset asserted while in HOLD_PEND -> PC = 3000 next edge; the pending target is never applied.
